// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package adder_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 16;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Round-robin candidate picker: first valid index at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the candidate with its own accept condition.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int N  = DEF_N_REQ,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  cand_oh,
    output logic [IW-1:0] cand_idx,
    output logic          cand_any
);

    logic [IW-1:0] scan_idx;

    // (base + off) mod N, with off < N so one conditional subtract suffices.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from farthest to nearest so the valid slot closest to ptr wins.
    always_comb begin
        cand_oh  = '0;
        cand_idx = '0;
        cand_any = 1'b0;
        scan_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = wrap_add(ptr, k);
            if (valid[scan_idx]) begin
                cand_oh           = '0;
                cand_oh[scan_idx] = 1'b1;
                cand_idx          = scan_idx;
                cand_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one W-bit adder among N_REQ requesters with round-robin grant; ADDER_ARB_SAT_EN saturates the sum on carry-out.
// Latency: accept at edge k gives rsp_valid from edge k (one registered stage), one response per cycle sustained.
// Backpressure: while rsp_valid && !rsp_ready no req_ready is raised and the response registers hold.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W,
    localparam int IW   = idx_w(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_carry,
    output logic [IW-1:0]      rsp_id,
    output logic [CNT_W-1:0]   txn_count
);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [N_REQ-1:0] cand_oh;
    logic [IW-1:0] cand_idx;
    logic          cand_any;
    logic          can_accept;
    logic          accept;
    logic          drain;
    logic [W-1:0]  a_sel, b_sel;
    logic [W:0]    sum_full;
    logic [W-1:0]  sum_out;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .valid    (req_valid),
        .ptr      (ptr_q),
        .cand_oh  (cand_oh),
        .cand_idx (cand_idx),
        .cand_any (cand_any)
    );

    assign rsp_valid  = (state_q == FULL);
    assign drain      = rsp_valid && rsp_ready;
    // A slot frees up either when empty or when the held result leaves this cycle.
    assign can_accept = !rst && ((state_q == IDLE) || drain);
    assign accept     = can_accept && cand_any;
    assign req_ready  = can_accept ? cand_oh : '0;

    // Operand mux and adder; operands are used straight from the requester, never latched.
    always_comb begin
        a_sel    = req_a[cand_idx*W +: W];
        b_sel    = req_b[cand_idx*W +: W];
        sum_full = {1'b0, a_sel} + {1'b0, b_sel};
`ifdef ADDER_ARB_SAT_EN
        sum_out  = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
        sum_out  = sum_full[W-1:0];
`endif
    end

    // Next state: a new accept always leaves FULL, otherwise a drain empties the slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FULL;
            FULL:    if (accept) state_d = FULL;
                     else if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, response registers and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            txn_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_sum   <= sum_out;
                rsp_carry <= sum_full[W];
                rsp_id    <= cand_idx;
                ptr_q     <= (cand_idx == IW'(N_REQ - 1)) ? '0 : cand_idx + 1'b1;
            end
            if (drain) txn_count <= txn_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic        rsp_ready;

    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic [1:0]  rsp_id;
    logic [15:0] txn_count;

    logic [3:0]  s_req_ready;
    logic        s_rsp_valid;
    logic [7:0]  s_rsp_sum;
    logic        s_rsp_carry;
    logic [1:0]  s_rsp_id;
    logic [3:0]  s_txn_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.N_REQ(4), .W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id), .txn_count(txn_count)
    );

    adder_rr_arbiter #(.N_REQ(4), .W(8), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(s_rsp_sum), .rsp_carry(s_rsp_carry), .rsp_id(s_rsp_id), .txn_count(s_txn_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    logic [7:0] exp_ovf;
    logic [7:0] held_sum;

    initial begin
        req_a = '0;
        req_b = '0;
`ifdef ADDER_ARB_SAT_EN
        exp_ovf = 8'hFF;
`else
        exp_ovf = 8'h10;
`endif

        // Reset state; requests presented during reset get no grant.
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
        step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_sum",   32'(rsp_sum),   32'h0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_txn",       32'(txn_count), 32'h0);
        req_valid = '0; rsp_ready = 1'b0;
        rst = 1'b0;
        step();

        // Single request on requester 2.
        set_ops(2, 8'h12, 8'h34);
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1 chk("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_sum",   32'(rsp_sum),   32'h46);
        chk("single_carry", 32'(rsp_carry), 32'h0);
        chk("single_id",    32'(rsp_id),    32'h2);
        step();
        chk("single_txn",   32'(txn_count), 32'h1);
        chk("single_idle",  32'(rsp_valid), 32'h0);

        // Fairness: all requesters valid, grants rotate from 0.
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 8'(8'h10 * i), 8'(i));
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
            chk("fair_id",  32'(rsp_id),  32'(k % 4));
            chk("fair_sum", 32'(rsp_sum), 32'(8'h11 * (k % 4)));
        end
        req_valid = '0;
        chk("fair_txn7", 32'(txn_count), 32'd7);
        step();
        chk("fair_txn8", 32'(txn_count), 32'd8);

        // Backpressure: requesters 1 and 3 pending, consumer stalled.
        set_ops(1, 8'h05, 8'h07);
        set_ops(3, 8'h30, 8'h0F);
        req_valid = 4'b1010; rsp_ready = 1'b0;
        #1 chk("bp_first_ready", 32'(req_ready), 32'h2);
        step();
        held_sum = 8'h0C;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_ready_low", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id",    32'(rsp_id),    32'h1);
            chk("bp_sum",   32'(rsp_sum),   32'(held_sum));
            step();
        end
        chk("bp_txn_hold", 32'(txn_count), 32'd8);
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        chk("bp_swap_valid", 32'(rsp_valid), 32'h1);
        chk("bp_swap_id",    32'(rsp_id),    32'h3);
        chk("bp_swap_sum",   32'(rsp_sum),   32'h3F);
        chk("bp_swap_txn",   32'(txn_count), 32'd9);
        step();
        chk("bp_txn_end",    32'(txn_count), 32'd10);

        // Overflow on requester 0.
        set_ops(0, 8'hF0, 8'h20);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("ovf_sum",   32'(rsp_sum),   32'(exp_ovf));
        chk("ovf_carry", 32'(rsp_carry), 32'h1);
        chk("ovf_id",    32'(rsp_id),    32'h0);
        step();
        chk("ovf_txn",   32'(txn_count), 32'd11);

        // Reset while FULL discards the result and clears the pointer.
        set_ops(1, 8'h01, 8'h01);
        req_valid = 4'b0010; rsp_ready = 1'b0;
        step();
        chk("mid_full", 32'(rsp_valid), 32'h1);
        rst = 1'b1; req_valid = '0;
        step();
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_txn",   32'(txn_count), 32'h0);
        rst = 1'b0;
        set_ops(0, 8'h02, 8'h03);
        set_ops(3, 8'h09, 8'h09);
        req_valid = 4'b1001; rsp_ready = 1'b1;
        #1 chk("mid_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("mid_id",  32'(rsp_id),  32'h0);
        chk("mid_sum", 32'(rsp_sum), 32'h05);
        step();

        // Counter wrap with a 4-bit counter: 17 transactions end at 1.
        do_reset();
        set_ops(0, 8'h01, 8'h02);
        req_valid = 4'b0001; rsp_ready = 1'b1;
        repeat (17) step();
        req_valid = '0;
        chk("wrap_small_16", 32'(s_txn_count), 32'd0);
        step();
        chk("wrap_small_17", 32'(s_txn_count), 32'd1);
        chk("wrap_big_17",   32'(txn_count),   32'd17);
        chk("wrap_idle",     32'(s_rsp_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Shares one W-bit adder datapath between N_REQ requesters. Requests are granted round-robin under valid/ready handshakes, and results are returned through a single registered response channel tagged with the requester ID. The block sits between the tile's input-decode logic and the output pins. It sequences every use of the adder so that only one operand pair is in flight at a time.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 8, operand and sum width
- CNT_W, 16, width of the completed-transaction counter

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand-pair valid
- req_a  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W]
- req_b  in  N_REQ*W  operand B; same packing as req_a
- req_ready  out  N_REQ  one-hot grant; at most one bit high per cycle
- rsp_valid  out  1  response holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_sum  out  W  result
- rsp_carry  out  1  carry-out of the addition
- rsp_id  out  $clog2(N_REQ)  index of the granted requester
- txn_count  out  CNT_W  number of completed responses

## Operation
- FSM has two states:
  - IDLE: no result held.
  - FULL: result held, rsp_valid=1.
- Arbitration:
  - Round-robin pointer `ptr`; the search starts at index ptr and wraps modulo N_REQ.
  - The first i with req_valid[i]=1 is the candidate.
  - req_ready[cand] is combinational and asserted only when can_accept = (state==IDLE) || (rsp_valid && rsp_ready).
- Accept happens when req_valid[i] && req_ready[i]. At that edge:
  - {rsp_carry, rsp_sum} <= req_a[i] + req_b[i], computed at W+1 bits.
  - rsp_id <= i.
  - ptr <= (i+1) mod N_REQ.
  - State goes to FULL.
- Drain happens when rsp_valid && rsp_ready with no new accept. State goes to IDLE.
- Drain and accept in the same cycle: state stays FULL and the new result replaces the old. This gives one transaction per cycle.
- txn_count increments by 1 on every drain and wraps from 2^CNT_W-1 to 0.
- ptr does not move when no request is accepted.
- The response registers hold stable while rsp_valid && !rsp_ready.
- Requesters must hold req_a, req_b and req_valid until their ready bit is seen. The block does not latch operands before the grant.

## Timing
- Reset values: state=IDLE, ptr=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, txn_count=0. req_ready=0 during reset.
- Reset during FULL discards the held result; no drain and no count increment occur.
- Latency: accept at edge k, rsp_valid=1 from edge k onward (visible in cycle k+1).
- Throughput: 1 response per cycle while rsp_ready stays high.
- When all requesters are valid continuously, grants rotate 0,1,…,N_REQ-1,0. The worst-case wait is N_REQ-1 grants.
- req_ready depends combinationally on req_valid, state and rsp_ready.
- rsp_* are driven directly from registers.

## Configuration
- ADDER_ARB_SAT_EN:
  - Defined: on carry-out the sum saturates, so rsp_sum = {W{1'b1}}; rsp_carry still reports overflow.
  - Undefined: rsp_sum wraps modulo 2^W.
  - Arbitration and timing are identical in both builds.

## Structure
- Package `adder_arb_pkg`:
  - State enum (IDLE, FULL).
  - Default constants for N_REQ, W, CNT_W.
  - Index-width function.
- One sub-module, `rr_pick`:
  - Combinational.
  - Inputs: valid vector and ptr.
  - Outputs: one-hot candidate, index, and any-valid flag.
- Top-level contents: FSM, response registers, counter, saturation logic.

## Test plan
- Single request: reset, then req_valid[2]=1, a=0x12, b=0x34, rsp_ready=1.
  - req_ready[2] goes high; next cycle rsp_valid=1, sum=0x46, carry=0, id=2, txn_count goes to 1.
- Fairness: all four requesters valid for 8 cycles, rsp_ready=1.
  - rsp_id sequence is 0,1,2,3,0,1,2,3 and txn_count=8.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending.
  - Response stays stable, req_ready=0, ptr unchanged.
  - After release, one drain and one accept occur in the same cycle.
- Overflow: a=0xF0, b=0x20.
  - Without the macro: sum=0x10, carry=1.
  - With ADDER_ARB_SAT_EN: sum=0xFF, carry=1.
- Reset mid-operation: assert rst while FULL.
  - Next cycle rsp_valid=0, txn_count=0, ptr=0.
  - First grant after reset goes to the lowest valid index.
- Counter wrap: set CNT_W=4 and run 17 transactions.
  - txn_count ends at 1.
